// File: rtl/hazard_tracker_pkg.sv
// Shared definitions for the execute-stage hazard tracker and the operand muxes.
package hazard_tracker_pkg;

  // Operand source select, shared with the SrcA/SrcB muxes in execute.
  typedef enum logic [1:0] {
    FWD_RD1     = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUM    = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_tracker_fwd_select.sv
// Forward-select for one execute-stage source operand; M (newest) beats W.
module fwd_select
  import hazard_tracker_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] RsE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteW,
  output fwd_sel_e                  Sel
);

  logic w_hit_m;
  logic w_hit_w;

  // Match checks; x0 is hard-wired zero and is never forwarded.
  always_comb begin
    w_hit_m = RegWriteM && (RdM != '0) && (RdM == RsE);
    w_hit_w = RegWriteW && (RdW != '0) && (RdW == RsE);
  end

  // Priority select: M stage first, then W stage, else register file.
  always_comb begin
    Sel = FWD_RD1;
    if (w_hit_m)      Sel = FWD_ALUM;
    else if (w_hit_w) Sel = FWD_RESULTW;
  end

endmodule

// File: rtl/hazard_tracker.sv
// Execute-stage hazard tracker: shadow E/M/W register-use pipeline,
// forwarding selects, load-use stall, branch/bubble flush and perf counters.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic                      RegWriteD,
  input  logic                      LoadD,
  input  logic                      PCSrcE,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [CNT_WIDTH-1:0]      StallCount,
  output logic [CNT_WIDTH-1:0]      FlushCount
);

  // E stage shadow
  logic [REG_ADDR_WIDTH-1:0] r_rs1_e;
  logic [REG_ADDR_WIDTH-1:0] r_rs2_e;
  logic [REG_ADDR_WIDTH-1:0] r_rd_e;
  logic                      r_regwrite_e;
  logic                      r_load_e;
  // M stage shadow
  logic [REG_ADDR_WIDTH-1:0] r_rd_m;
  logic                      r_regwrite_m;
  // W stage shadow
  logic [REG_ADDR_WIDTH-1:0] r_rd_w;
  logic                      r_regwrite_w;
  // Performance counters
  logic [CNT_WIDTH-1:0]      r_stall_cnt;
  logic [CNT_WIDTH-1:0]      r_flush_cnt;

  logic                      w_lw_stall;
  logic                      w_flush_e;
  fwd_sel_e                  w_fwd_a;
  fwd_sel_e                  w_fwd_b;

  // Load-use detection and pipeline control
  always_comb begin
    w_lw_stall = r_load_e && (r_rd_e != '0) &&
                 ((r_rd_e == Rs1D) || (r_rd_e == Rs2D));
    w_flush_e  = w_lw_stall || PCSrcE;
  end

  // D->E capture; a flushed ID/EX register becomes an all-zero bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs1_e      <= '0;
      r_rs2_e      <= '0;
      r_rd_e       <= '0;
      r_regwrite_e <= 1'b0;
      r_load_e     <= 1'b0;
    end else if (w_flush_e) begin
      r_rs1_e      <= '0;
      r_rs2_e      <= '0;
      r_rd_e       <= '0;
      r_regwrite_e <= 1'b0;
      r_load_e     <= 1'b0;
    end else begin
      r_rs1_e      <= Rs1D;
      r_rs2_e      <= Rs2D;
      r_rd_e       <= RdD;
      r_regwrite_e <= RegWriteD;
      r_load_e     <= LoadD;
    end
  end

  // E->M->W always advance; bubbles propagate as zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_m       <= '0;
      r_regwrite_m <= 1'b0;
      r_rd_w       <= '0;
      r_regwrite_w <= 1'b0;
    end else begin
      r_rd_m       <= r_rd_e;
      r_regwrite_m <= r_regwrite_e;
      r_rd_w       <= r_rd_m;
      r_regwrite_w <= r_regwrite_m;
    end
  end

  // Saturating event counters; both may step on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_lw_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (PCSrcE && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
    end
  end

  fwd_select #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_a (
    .RsE       (r_rs1_e),
    .RdM       (r_rd_m),
    .RegWriteM (r_regwrite_m),
    .RdW       (r_rd_w),
    .RegWriteW (r_regwrite_w),
    .Sel       (w_fwd_a)
  );

  fwd_select #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_b (
    .RsE       (r_rs2_e),
    .RdM       (r_rd_m),
    .RegWriteM (r_regwrite_m),
    .RdW       (r_rd_w),
    .RegWriteW (r_regwrite_w),
    .Sel       (w_fwd_b)
  );

  // Output drive
  always_comb begin
    ForwardAE  = w_fwd_a;
    ForwardBE  = w_fwd_b;
    StallF     = w_lw_stall;
    StallD     = w_lw_stall;
    FlushD     = PCSrcE;
    FlushE     = w_flush_e;
    StallCount = r_stall_cnt;
    FlushCount = r_flush_cnt;
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench for hazard_tracker: stimulus pushes model expectations,
// a monitor pops and compares one entry per cycle at the falling edge.
module tb_hazard_tracker;

  localparam int unsigned AW      = 5;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] Rs1D = '0, Rs2D = '0, RdD = '0;
  logic          RegWriteD = 1'b0, LoadD = 1'b0, PCSrcE = 1'b0;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, FlushD, FlushE;
  logic [CW-1:0] StallCount, FlushCount;

  hazard_tracker #(
    .REG_ADDR_WIDTH (AW),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdD        (RdD),
    .RegWriteD  (RegWriteD),
    .LoadD      (LoadD),
    .PCSrcE     (PCSrcE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .StallCount (StallCount),
    .FlushCount (FlushCount)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int rs1, rs2, rd;
    bit we, ld;
  } instr_t;

  typedef struct {
    int fa, fb;
    bit stall, flushd, flushe;
    int sc, fc;
  } exp_t;

  instr_t pipe[$];   // [0] = instruction in E, [1] = M, [2] = W
  exp_t   sb[$];
  int     m_sc, m_fc;
  int     n_tests = 0, n_fail = 0;

  function automatic instr_t bubble();
    instr_t b;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.we = 0; b.ld = 0;
    return b;
  endfunction

  // Where does the newest value of register rs live for the instruction in E?
  function automatic int fwd_of(int rs);
    if (rs == 0) return 0;
    if (pipe[1].we && pipe[1].rd == rs) return 2;
    if (pipe[2].we && pipe[2].rd == rs) return 1;
    return 0;
  endfunction

  task automatic model_clear();
    pipe.delete();
    repeat (3) pipe.push_back(bubble());
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic drive(int rs1, int rs2, int rd, bit we, bit ld, bit pc);
    Rs1D = AW'(rs1); Rs2D = AW'(rs2); RdD = AW'(rd);
    RegWriteD = we; LoadD = ld; PCSrcE = pc;
  endtask

  // One normal pipeline cycle: called at posedge+1, returns at next posedge+1.
  task automatic step(int rs1, int rs2, int rd, bit we, bit ld, bit pc);
    exp_t   e;
    instr_t d;
    bit     stall;
    drive(rs1, rs2, rd, we, ld, pc);
    stall = pipe[0].ld && pipe[0].rd != 0 &&
            (pipe[0].rd == rs1 || pipe[0].rd == rs2);
    e.fa = fwd_of(pipe[0].rs1);
    e.fb = fwd_of(pipe[0].rs2);
    e.stall = stall; e.flushd = pc; e.flushe = stall | pc;
    e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    @(posedge clk); #1;
    d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.we = we; d.ld = ld;
    pipe.push_front((stall | pc) ? bubble() : d);
    void'(pipe.pop_back());
    if (stall) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
    if (pc)    m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
  endtask

  // Reset raised mid-cycle; everything must clear before the falling edge.
  task automatic reset_cycle(int rs1, int rs2, int rd, bit we, bit ld, bit pc);
    exp_t e;
    drive(rs1, rs2, rd, we, ld, pc);
    rst = 1'b1;
    model_clear();
    e.fa = 0; e.fb = 0; e.stall = 0; e.flushd = pc; e.flushe = pc;
    e.sc = 0; e.fc = 0;
    sb.push_back(e);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ForwardAE",  int'(ForwardAE),  e.fa);
        chk("ForwardBE",  int'(ForwardBE),  e.fb);
        chk("StallF",     int'(StallF),     int'(e.stall));
        chk("StallD",     int'(StallD),     int'(e.stall));
        chk("FlushD",     int'(FlushD),     int'(e.flushd));
        chk("FlushE",     int'(FlushE),     int'(e.flushe));
        chk("StallCount", int'(StallCount), e.sc);
        chk("FlushCount", int'(FlushCount), e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    @(posedge clk); #1;
    reset_cycle(0, 0, 0, 0, 0, 0);

    // back-to-back RAW: add x5 ; add x6,x5,x1
    step(1, 2, 5, 1, 0, 0); step(5, 1, 6, 1, 0, 0); nop(); nop();
    // add x5 ; nop ; sub x7,x2,x5
    step(1, 2, 5, 1, 0, 0); nop(); step(2, 5, 7, 1, 0, 0); nop(); nop();
    // two writers of x5 in M and W
    step(1, 1, 5, 1, 0, 0); step(2, 2, 5, 1, 0, 0); step(5, 0, 6, 1, 0, 0); nop(); nop();
    // lw x5 ; add x6,x5,x0 (held in D for one stall cycle)
    step(1, 0, 5, 1, 1, 0); step(5, 0, 6, 1, 0, 0); step(5, 0, 6, 1, 0, 0); nop(); nop();
    // x0 writers and lw x0 followed by use of x0
    step(0, 0, 0, 1, 0, 0); step(0, 0, 0, 1, 0, 0); step(0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0); step(0, 0, 2, 1, 0, 0); nop(); nop();
    // taken branch: next E is a bubble
    step(1, 2, 5, 1, 0, 0); step(5, 5, 6, 1, 0, 1); step(6, 5, 7, 1, 0, 0); nop(); nop();
    // load-use then branch in the same cycle
    step(1, 0, 4, 1, 1, 0); step(4, 4, 8, 1, 0, 1); nop(); nop();
    // reset asserted while a load-use stall is being signalled
    step(1, 0, 3, 1, 1, 0); reset_cycle(3, 0, 4, 1, 0, 0); nop(); nop();
    // counter saturation: 20 stalls and 20 flushes into a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 3, 1, 1, 0);
      step(3, 3, 4, 1, 0, 1);
    end
    nop(); nop();

    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0)
        reset_cycle($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      else
        step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 7) == 0));
    end

    @(negedge clk); @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
